// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Constants and types shared by the back-end pipeline stages (EX_MEM and
// mem_writeback_stage).
//   DATA_WIDTH     : datapath and memory word width
//   REG_ADDR_WIDTH : register-file address width
//   MEM_DEPTH      : default data-memory depth in words
//   ADDR_WIDTH     : default word-address width (log2 MEM_DEPTH)
//   wb_ctrl_t      : write-back control bundle carried by EX_MEM and MEM/WB
//   move_cond()    : movn/movz qualification of a register write
// -----------------------------------------------------------------------------
package mips_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int MEM_DEPTH      = 1024;
  localparam int ADDR_WIDTH     = 10;

  typedef struct packed {
    logic RegWrite;
    logic MemToReg;
    logic HiLoToReg;
    logic HiOrLo;
    logic DontMove;
    logic MoveNotZero;
  } wb_ctrl_t;

  // DontMove marks an ordinary write. Otherwise the write only happens when
  // the RD2 operand matches the movn (non-zero) or movz (zero) condition.
  function automatic logic move_cond(input wb_ctrl_t ctrl,
                                     input logic [DATA_WIDTH-1:0] rd2);
    return ctrl.DontMove | (ctrl.MoveNotZero ? (rd2 != '0) : (rd2 == '0));
  endfunction

endpackage

// File: rtl/mem_writeback_stage_if.sv
// -----------------------------------------------------------------------------
// mem_writeback_stage_if
// Bundles the EX_MEM outputs feeding the MEM stage, the Flush request, and
// the branch-redirect and write-back results leaving it.
//   master : EX_MEM / hazard-unit side (drives EX_MEM fields and Flush,
//            observes branch redirect and write-back path)
//   slave  : mem_writeback_stage side
// -----------------------------------------------------------------------------
interface mem_writeback_stage_if import mips_pkg::*; ();

  // EX_MEM -> MEM
  logic                      Flush;
  logic                      RegWriteIn;
  logic                      MemToRegIn;
  logic                      HiLoToRegIn;
  logic                      HiOrLoIn;
  logic                      DontMoveIn;
  logic                      MoveNotZeroIn;
  logic                      MemWriteIn;
  logic                      MemReadIn;
  logic                      BranchIn;
  logic                      ZeroIn;
  logic [DATA_WIDTH-1:0]     AddResultIn;
  logic [DATA_WIDTH-1:0]     ALUResultIn;
  logic [DATA_WIDTH-1:0]     RD2In;
  logic [DATA_WIDTH-1:0]     RHiIn;
  logic [DATA_WIDTH-1:0]     RLoIn;
  logic [REG_ADDR_WIDTH-1:0] WriteAddressIn;

  // MEM -> IF (branch redirect) and WB -> ID (register write)
  logic                      BranchTaken;
  logic [DATA_WIDTH-1:0]     BranchAddress;
  logic [REG_ADDR_WIDTH-1:0] WriteRegister;
  logic [DATA_WIDTH-1:0]     WriteData;
  logic                      RegWrite;
  logic                      Move;

  modport master (
    output Flush, RegWriteIn, MemToRegIn, HiLoToRegIn, HiOrLoIn, DontMoveIn,
           MoveNotZeroIn, MemWriteIn, MemReadIn, BranchIn, ZeroIn,
           AddResultIn, ALUResultIn, RD2In, RHiIn, RLoIn, WriteAddressIn,
    input  BranchTaken, BranchAddress, WriteRegister, WriteData, RegWrite, Move
  );

  modport slave (
    input  Flush, RegWriteIn, MemToRegIn, HiLoToRegIn, HiOrLoIn, DontMoveIn,
           MoveNotZeroIn, MemWriteIn, MemReadIn, BranchIn, ZeroIn,
           AddResultIn, ALUResultIn, RD2In, RHiIn, RLoIn, WriteAddressIn,
    output BranchTaken, BranchAddress, WriteRegister, WriteData, RegWrite, Move
  );

endinterface

// File: rtl/mem_writeback_stage_data_memory.sv
// -----------------------------------------------------------------------------
// data_memory
// Synchronous single-port data RAM, read-before-write.
//   Clk       : rising-edge clock
//   Rst       : asynchronous active-low reset (read register only)
//   MemWrite  : write strobe, already qualified by the caller
//   MemRead   : read enable; a disabled read returns 0
//   Address   : word address
//   WriteData : store data
//   ReadData  : registered read data (the MEM/WB memdata field)
// -----------------------------------------------------------------------------
module data_memory import mips_pkg::*; #(
  parameter int MEM_DEPTH  = mips_pkg::MEM_DEPTH,
  parameter int ADDR_WIDTH = mips_pkg::ADDR_WIDTH
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  MemWrite,
  input  logic                  MemRead,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [DATA_WIDTH-1:0] WriteData,
  output logic [DATA_WIDTH-1:0] ReadData
);

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] read_data_q;

  // NOTE: the array has no reset; clearing it would turn the RAM into a
  // flop bank, and the contents are allowed to survive a reset anyway.
  always_ff @(posedge Clk) begin
    if (MemWrite) begin
      mem_q[Address] <= WriteData;
    end
  end

  // Sampled on the same edge as the write, so a same-address access sees
  // the old word.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      read_data_q <= '0;
    end else begin
      read_data_q <= MemRead ? mem_q[Address] : '0;
    end
  end

  assign ReadData = read_data_q;

endmodule

// File: rtl/mem_writeback_stage.sv
// -----------------------------------------------------------------------------
// mem_writeback_stage
// Back end of the five-stage MIPS pipeline: data-memory access, MEM/WB
// pipeline register and write-back select, plus the branch redirect to IF.
//   Clk  : rising-edge clock
//   Rst  : asynchronous active-low reset (clears MEM/WB, not the memory)
//   bus  : slave side of mem_writeback_stage_if
//          in : Flush, EX_MEM control bits, AddResultIn, ALUResultIn, RD2In,
//               RHiIn, RLoIn, WriteAddressIn
//          out: BranchTaken, BranchAddress (to IF),
//               WriteRegister, WriteData, RegWrite, Move (to ID)
// -----------------------------------------------------------------------------
module mem_writeback_stage import mips_pkg::*; #(
  parameter int MEM_DEPTH  = mips_pkg::MEM_DEPTH,
  parameter int ADDR_WIDTH = mips_pkg::ADDR_WIDTH
) (
  input  logic                  Clk,
  input  logic                  Rst,
  mem_writeback_stage_if.slave  bus
);

  wb_ctrl_t                  ctrl_in;
  wb_ctrl_t                  ctrl_d;
  wb_ctrl_t                  ctrl_q;
  logic [DATA_WIDTH-1:0]     alu_result_q;
  logic [DATA_WIDTH-1:0]     rd2_q;
  logic [DATA_WIDTH-1:0]     rhi_q;
  logic [DATA_WIDTH-1:0]     rlo_q;
  logic [REG_ADDR_WIDTH-1:0] write_address_q;
  logic [DATA_WIDTH-1:0]     mem_data;
  logic [DATA_WIDTH-1:0]     write_data;
  logic                      mem_we;
  logic                      move;

  // ---------------------------------------------------------------------------
  // Branch redirect: purely combinational, IF samples it on the next edge.
  // ---------------------------------------------------------------------------
  assign bus.BranchTaken   = bus.BranchIn & bus.ZeroIn & ~bus.Flush;
  assign bus.BranchAddress = bus.AddResultIn;

  // ---------------------------------------------------------------------------
  // Data memory. Byte offset and bits above the word index are dropped, so
  // misaligned addresses round down and the space wraps at MEM_DEPTH.
  // A store is dropped when the instruction is flushed or reset is held.
  // ---------------------------------------------------------------------------
  assign mem_we = bus.MemWriteIn & ~bus.Flush & Rst;

  data_memory #(
    .MEM_DEPTH  (MEM_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_data_memory (
    .Clk       (Clk),
    .Rst       (Rst),
    .MemWrite  (mem_we),
    .MemRead   (bus.MemReadIn),
    .Address   (bus.ALUResultIn[ADDR_WIDTH+1:2]),
    .WriteData (bus.RD2In),
    .ReadData  (mem_data)
  );

  // ---------------------------------------------------------------------------
  // MEM/WB register. A flush turns the control bundle into a bubble; the
  // data fields still load because nothing downstream looks at them.
  // ---------------------------------------------------------------------------
  assign ctrl_in = '{
    RegWrite:    bus.RegWriteIn,
    MemToReg:    bus.MemToRegIn,
    HiLoToReg:   bus.HiLoToRegIn,
    HiOrLo:      bus.HiOrLoIn,
    DontMove:    bus.DontMoveIn,
    MoveNotZero: bus.MoveNotZeroIn
  };

  assign ctrl_d = bus.Flush ? '0 : ctrl_in;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      ctrl_q          <= '0;
      alu_result_q    <= '0;
      rd2_q           <= '0;
      rhi_q           <= '0;
      rlo_q           <= '0;
      write_address_q <= '0;
    end else begin
      ctrl_q          <= ctrl_d;
      alu_result_q    <= bus.ALUResultIn;
      rd2_q           <= bus.RD2In;
      rhi_q           <= bus.RHiIn;
      rlo_q           <= bus.RLoIn;
      write_address_q <= bus.WriteAddressIn;
    end
  end

  // ---------------------------------------------------------------------------
  // Write-back select: HI/LO beats memory, memory beats the ALU result.
  // ---------------------------------------------------------------------------
  // NOTE: the output gets a default before any branch so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    write_data = alu_result_q;
    if (ctrl_q.HiLoToReg) begin
      write_data = ctrl_q.HiOrLo ? rhi_q : rlo_q;
    end else if (ctrl_q.MemToReg) begin
      write_data = mem_data;
    end
  end

  // After reset rd2_q is 0 and MoveNotZero is 0, so Move reads 1 (movz on
  // zero); RegWrite is 0 in that state so it never causes a write.
  assign move = move_cond(ctrl_q, rd2_q);

  assign bus.Move          = move;
  assign bus.WriteData     = write_data;
  assign bus.WriteRegister = write_address_q;
  // Register $0 is hard-wired to zero and must never be written.
  assign bus.RegWrite      = ctrl_q.RegWrite & move & (write_address_q != '0);

endmodule

// File: tb/tb_mem_writeback_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_writeback_stage
// Self-checking bench for mem_writeback_stage: reset state, a table of
// directed single-cycle vectors, an asynchronous-reset sequence, and random
// traffic checked against a behavioural model (memory array + formulas).
// -----------------------------------------------------------------------------
module tb_mem_writeback_stage;
  import mips_pkg::*;

  logic Clk = 1'b0;
  logic Rst = 1'b0;

  mem_writeback_stage_if bus ();

  mem_writeback_stage #(
    .MEM_DEPTH  (1024),
    .ADDR_WIDTH (10)
  ) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        flush, rw, m2r, hl, hol, dm, mnz, mw, mr, br, z;
    logic [31:0] add, alu, rd2, hi, lo;
    logic [4:0]  wa;
    logic        exp_bt, exp_rw, exp_mv;
    logic [31:0] exp_wd;
    logic        chk_wd;   // 0 for flushed vectors: data fields are don't-care
  } vec_t;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] mem_m [1024];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // c = {flush, rw, m2r, hl, hol, dm, mnz, mw, mr, br, z}
  function automatic vec_t mk(input logic [10:0] c, input logic [31:0] alu,
                              input logic [31:0] rd2, input logic [4:0] wa,
                              input logic bt, input logic rwe, input logic mv,
                              input logic [31:0] wd, input logic chk);
    vec_t v;
    {v.flush, v.rw, v.m2r, v.hl, v.hol, v.dm, v.mnz, v.mw, v.mr, v.br, v.z} = c;
    v.alu = alu;  v.rd2 = rd2;  v.wa = wa;
    v.add = 32'h0000_0100;  v.hi = 32'hAAAA_0000;  v.lo = 32'h5555_FFFF;
    v.exp_bt = bt;  v.exp_rw = rwe;  v.exp_mv = mv;  v.exp_wd = wd;  v.chk_wd = chk;
    return v;
  endfunction

  // Reference: what the write-back port must show one cycle after v is
  // presented, using the memory contents as they stand before that edge.
  function automatic vec_t model(input vec_t v);
    vec_t        r = v;
    logic [31:0] rdata;
    rdata    = v.mr ? mem_m[v.alu[11:2]] : 32'h0;
    r.exp_bt = v.br && v.z && !v.flush;
    r.exp_mv = v.dm || (v.mnz ? (v.rd2 != 0) : (v.rd2 == 0));
    r.exp_rw = !v.flush && v.rw && r.exp_mv && (v.wa != 0);
    if (v.hl)       r.exp_wd = v.hol ? v.hi : v.lo;
    else if (v.m2r) r.exp_wd = rdata;
    else            r.exp_wd = v.alu;
    r.chk_wd = !v.flush;
    return r;
  endfunction

  task automatic drive(input vec_t v);
    bus.Flush         = v.flush;
    bus.RegWriteIn    = v.rw;
    bus.MemToRegIn    = v.m2r;
    bus.HiLoToRegIn   = v.hl;
    bus.HiOrLoIn      = v.hol;
    bus.DontMoveIn    = v.dm;
    bus.MoveNotZeroIn = v.mnz;
    bus.MemWriteIn    = v.mw;
    bus.MemReadIn     = v.mr;
    bus.BranchIn      = v.br;
    bus.ZeroIn        = v.z;
    bus.AddResultIn   = v.add;
    bus.ALUResultIn   = v.alu;
    bus.RD2In         = v.rd2;
    bus.RHiIn         = v.hi;
    bus.RLoIn         = v.lo;
    bus.WriteAddressIn = v.wa;
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic apply(input vec_t v, input bit chk, input string name);
    drive(v);
    #1;
    if (chk) begin
      check({name, " BranchTaken"}, 32'(bus.BranchTaken), 32'(v.exp_bt));
      check({name, " BranchAddress"}, bus.BranchAddress, v.add);
    end
    if (v.mw && !v.flush && Rst) mem_m[v.alu[11:2]] = v.rd2;
    @(posedge Clk);
    #1;
    if (chk) begin
      check({name, " RegWrite"}, 32'(bus.RegWrite), 32'(v.exp_rw));
      if (v.chk_wd) begin
        check({name, " Move"}, 32'(bus.Move), 32'(v.exp_mv));
        check({name, " WriteData"}, bus.WriteData, v.exp_wd);
        check({name, " WriteRegister"}, 32'(bus.WriteRegister), 32'(v.wa));
      end
    end
    @(negedge Clk);
  endtask

  initial begin
    vec_t tbl [21];
    vec_t v;

    //                f rw m2 hl ho dm mz mw mr br z   alu           rd2           wa  bt rw mv wd            chk
    tbl[0]  = mk(11'b0_0_0_0_0_1_0_1_0_0_0, 32'h40,   32'hDEADBEEF, 0,  0, 0, 1, 32'h40,       1); // sw 0x40
    tbl[1]  = mk(11'b0_1_1_0_0_1_0_0_1_0_0, 32'h40,   32'h0,        8,  0, 1, 1, 32'hDEADBEEF, 1); // lw 0x40
    tbl[2]  = mk(11'b0_0_0_0_0_1_0_1_0_0_0, 32'h1002, 32'h1234,     0,  0, 0, 1, 32'h1002,     1); // sw wraps to word 0
    tbl[3]  = mk(11'b0_1_1_0_0_1_0_0_1_0_0, 32'h0,    32'h0,        3,  0, 1, 1, 32'h1234,     1); // lw 0x0
    tbl[4]  = mk(11'b0_1_0_0_0_0_1_0_0_0_0, 32'h77,   32'h0,        4,  0, 0, 0, 32'h77,       1); // movn, rd2=0
    tbl[5]  = mk(11'b0_1_0_0_0_0_1_0_0_0_0, 32'h77,   32'h5,        4,  0, 1, 1, 32'h77,       1); // movn, rd2=5
    tbl[6]  = mk(11'b0_1_0_0_0_0_0_0_0_0_0, 32'h77,   32'h0,        4,  0, 1, 1, 32'h77,       1); // movz, rd2=0
    tbl[7]  = mk(11'b0_1_0_0_0_0_0_0_0_0_0, 32'h77,   32'h9,        4,  0, 0, 0, 32'h77,       1); // movz, rd2=9
    tbl[8]  = mk(11'b0_1_0_1_1_1_0_0_0_0_0, 32'h33,   32'h0,        2,  0, 1, 1, 32'hAAAA0000, 1); // mfhi
    tbl[9]  = mk(11'b0_1_0_1_0_1_0_0_0_0_0, 32'h33,   32'h0,        2,  0, 1, 1, 32'h5555FFFF, 1); // mflo
    tbl[10] = mk(11'b0_1_1_1_0_1_0_0_1_0_0, 32'h40,   32'h0,        2,  0, 1, 1, 32'h5555FFFF, 1); // HiLo beats mem
    tbl[11] = mk(11'b0_1_0_0_0_1_0_0_0_0_0, 32'h99,   32'h0,        0,  0, 0, 1, 32'h99,       1); // write to $0
    tbl[12] = mk(11'b0_0_0_0_0_1_0_0_0_1_1, 32'h10,   32'h0,        0,  1, 0, 1, 32'h10,       1); // branch taken
    tbl[13] = mk(11'b0_0_0_0_0_1_0_0_0_1_0, 32'h10,   32'h0,        0,  0, 0, 1, 32'h10,       1); // branch, Zero=0
    tbl[14] = mk(11'b1_1_0_0_0_1_0_1_0_1_1, 32'h40,   32'h0BADF00D, 7,  0, 0, 0, 32'h0,        0); // flush all
    tbl[15] = mk(11'b0_1_1_0_0_1_0_0_1_0_0, 32'h40,   32'h0,        9,  0, 1, 1, 32'hDEADBEEF, 1); // store was squashed
    tbl[16] = mk(11'b0_1_1_0_0_1_0_1_1_0_0, 32'h80,   32'h11112222, 10, 0, 1, 1, 32'h5A000020, 1); // read-before-write
    tbl[17] = mk(11'b0_1_1_0_0_1_0_0_1_0_0, 32'h80,   32'h0,        10, 0, 1, 1, 32'h11112222, 1); // new data visible
    tbl[18] = mk(11'b0_1_1_0_0_1_0_0_1_0_0, 32'h83,   32'h0,        11, 0, 1, 1, 32'h11112222, 1); // misaligned rounds down
    tbl[19] = mk(11'b0_1_1_0_0_1_0_0_0_0_0, 32'h80,   32'h0,        5,  0, 1, 1, 32'h0,        1); // MemRead=0 -> 0
    tbl[20] = mk(11'b0_1_1_0_0_1_0_0_1_0_0, 32'h1000, 32'h0,        12, 0, 1, 1, 32'h1234,     1); // wrap on read

    // Reset state.
    drive(mk(11'b0, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0, 0));
    #12;
    check("reset RegWrite", 32'(bus.RegWrite), 32'h0);
    check("reset WriteData", bus.WriteData, 32'h0);
    check("reset WriteRegister", 32'(bus.WriteRegister), 32'h0);
    check("reset Move", 32'(bus.Move), 32'h1);
    @(negedge Clk);
    Rst = 1'b1;

    // Give every word a known value so random loads have a defined answer.
    for (int i = 0; i < 1024; i++) begin
      apply(mk(11'b0_0_0_0_0_1_0_1_0_0_0, 32'(i * 4), 32'h5A000000 | 32'(i), 0,
               0, 0, 0, 32'h0, 0), 1'b0, "preload");
    end

    for (int i = 0; i < 21; i++) begin
      apply(tbl[i], 1'b1, $sformatf("vec%0d", i));
    end

    // Asynchronous reset mid-cycle with a write pending and a store queued.
    apply(mk(11'b0_1_0_0_0_1_0_0_0_0_0, 32'h1234, 32'h0, 6, 0, 1, 1, 32'h1234, 1),
          1'b1, "rst_pre");
    drive(mk(11'b0_0_0_0_0_1_0_1_0_0_0, 32'h40, 32'hFFFFFFFF, 0, 0, 0, 0, 32'h0, 0));
    #2;
    Rst = 1'b0;
    #1;
    check("async RegWrite", 32'(bus.RegWrite), 32'h0);
    check("async WriteData", bus.WriteData, 32'h0);
    check("async WriteRegister", 32'(bus.WriteRegister), 32'h0);
    @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b1;
    apply(mk(11'b0_1_1_0_0_1_0_0_1_0_0, 32'h40, 32'h0, 9, 0, 1, 1, 32'hDEADBEEF, 1),
          1'b1, "rst_store_lost");

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      {v.rw, v.m2r, v.hl, v.hol, v.dm, v.mnz, v.mw, v.mr, v.br, v.z} = 10'($urandom);
      v.flush = ($urandom_range(0, 7) == 0);
      v.add   = $urandom;
      v.alu   = $urandom;
      v.rd2   = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      v.hi    = $urandom;
      v.lo    = $urandom;
      v.wa    = 5'($urandom_range(0, 31));
      v = model(v);
      apply(v, 1'b1, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
